// File: rtl/lsu_mem_port.sv
// Load/store initiator: splits word-crossing accesses into two byte-enabled beats, reassembles loads.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests fault instead of splitting.
module lsu_mem_port #(
    parameter int unsigned N  = 64,
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [N-1:0]  req_addr,
    input  logic [N-1:0]  req_wdata,
    input  logic [2:0]    memWidth,
    output logic          resp_valid,
    output logic [N-1:0]  resp_data,
    output logic          resp_fault,
    output logic [AW-1:0] wordAddr,
    output logic [N-1:0]  DM_writeData,
    output logic [7:0]    byteena,
    output logic          readEnable,
    output logic          writeEnable,
    input  logic [N-1:0]  DM_readData
);

    typedef enum logic [2:0] {StIdle, StBeat0, StBeat1, StCapt, StResp} state_e;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_word, w_word;
    logic [2:0]    r_off, w_off;
    logic [2:0]    r_width;
    logic [1:0]    w_wlog;
    logic          r_write, w_write;
    logic [N-1:0]  r_wdata, w_wdata;
    logic [N-1:0]  r_lo;

    logic          r_resp_valid, r_fault, r_rd, r_wr;
    logic [N-1:0]  r_resp_data, r_wd;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_be;

    logic          w_accept, w_split, w_trap;
    logic [3:0]    w_size;
    logic [4:0]    w_end;
    logic [15:0]   w_mask;
    logic [2*N-1:0] w_wide;
    logic [N-1:0]  w_cat, w_load;
    logic          w_rd_d, w_wr_d;
    logic [7:0]    w_be_d;
    logic [AW-1:0] w_addr_d;
    logic [N-1:0]  w_wd_d;
    logic          w_unused_addr;

    assign w_unused_addr = ^req_addr[N-1:AW+3];

    // Beat outputs are registered, so they are computed from the values about to be latched.
    assign w_accept = req_valid && (r_state == StIdle);
    assign w_word   = w_accept ? req_addr[AW+2:3] : r_word;
    assign w_off    = w_accept ? req_addr[2:0]    : r_off;
    assign w_wlog   = w_accept ? memWidth[1:0]    : r_width[1:0];
    assign w_write  = w_accept ? req_write        : r_write;
    assign w_wdata  = w_accept ? req_wdata        : r_wdata;

    assign w_size  = 4'd1 << w_wlog;
    assign w_end   = {2'b00, w_off} + {1'b0, w_size};
    assign w_split = (w_end > 5'd8);
    assign w_mask  = ((16'd1 << w_size) - 16'd1) << w_off;
    assign w_wide  = {{N{1'b0}}, w_wdata} << {w_off, 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = w_accept && (({1'b0, w_off} & (w_size - 4'd1)) != 4'd0);
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = w_trap ? StResp : StBeat0;
            StBeat0: begin
                if (w_split)      w_state_d = StBeat1;
                else if (w_write) w_state_d = StResp;
                else              w_state_d = StCapt;
            end
            StBeat1: w_state_d = w_write ? StResp : StCapt;
            StCapt:  w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Split loads: lo was captured during BEAT1, the live read data is the upper word.
    assign w_cat = N'({(w_split ? DM_readData : {N{1'b0}}),
                       (w_split ? r_lo : DM_readData)} >> {r_off, 3'b000});

    always_comb begin
        w_load = w_cat;
        unique case (r_width[1:0])
            2'd0: w_load = {{(N-8){~r_width[2] & w_cat[7]}}, w_cat[7:0]};
            2'd1: w_load = {{(N-16){~r_width[2] & w_cat[15]}}, w_cat[15:0]};
            2'd2: w_load = {{(N-32){~r_width[2] & w_cat[31]}}, w_cat[31:0]};
            default: w_load = w_cat;
        endcase
    end

    always_comb begin
        w_rd_d   = 1'b0;
        w_wr_d   = 1'b0;
        w_be_d   = 8'h00;
        w_addr_d = '0;
        w_wd_d   = '0;
        case (w_state_d)
            StBeat0: begin
                w_rd_d   = !w_write;
                w_wr_d   = w_write;
                w_be_d   = w_mask[7:0];
                w_addr_d = w_word;
                w_wd_d   = w_wide[N-1:0];
            end
            StBeat1: begin
                w_rd_d   = !w_write;
                w_wr_d   = w_write;
                w_be_d   = w_mask[15:8];
                w_addr_d = w_word + AW'(1);
                w_wd_d   = w_wide[2*N-1:N];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_word       <= '0;
            r_off        <= '0;
            r_width      <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_lo         <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_fault      <= 1'b0;
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_be         <= 8'h00;
            r_addr       <= '0;
            r_wd         <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_word  <= req_addr[AW+2:3];
                r_off   <= req_addr[2:0];
                r_width <= memWidth;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end
            if (r_state == StBeat1 && !r_write) r_lo <= DM_readData;
            r_resp_valid <= (w_state_d == StResp);
            r_fault      <= w_trap;
            if (w_state_d == StResp) r_resp_data <= (r_state == StCapt) ? w_load : '0;
            r_rd   <= w_rd_d;
            r_wr   <= w_wr_d;
            r_be   <= w_be_d;
            r_addr <= w_addr_d;
            r_wd   <= w_wd_d;
        end
    end

    assign req_ready    = (r_state == StIdle);
    assign resp_valid   = r_resp_valid;
    assign resp_data    = r_resp_data;
    assign resp_fault   = r_fault;
    assign wordAddr     = r_addr;
    assign DM_writeData = r_wd;
    assign byteena      = r_be;
    assign readEnable   = r_rd;
    assign writeEnable  = r_wr;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port: byte-level memory reference model plus fixed scenario tasks.
module tb_lsu_mem_port;
    localparam int N  = 64;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [N-1:0]  req_addr, req_wdata;
    logic [2:0]    memWidth;
    logic          resp_valid, resp_fault;
    logic [N-1:0]  resp_data, DM_writeData, DM_readData;
    logic [AW-1:0] wordAddr;
    logic [7:0]    byteena;
    logic          readEnable, writeEnable;

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0] mem     [4096];
    logic [N-1:0] ref_mem [4096];
    logic [N-1:0] rdata;
    logic [N-1:0] merge_w;
    logic         pl_en = 1'b0;
    logic [11:0]  pl_word;
    logic [N-1:0] pl_data;

    always #5 clk = ~clk;

    lsu_mem_port #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .memWidth(memWidth),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_fault(resp_fault),
        .wordAddr(wordAddr), .DM_writeData(DM_writeData), .byteena(byteena),
        .readEnable(readEnable), .writeEnable(writeEnable), .DM_readData(DM_readData)
    );

    // Byte-enabled synchronous memory; read data appears the cycle after readEnable.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_word] <= pl_data;
        end else if (writeEnable) begin
            merge_w = mem[wordAddr];
            for (int l = 0; l < 8; l++)
                if (byteena[l]) merge_w[8*l +: 8] = DM_writeData[8*l +: 8];
            mem[wordAddr] <= merge_w;
        end
        if (readEnable) rdata <= mem[wordAddr];
    end
    assign DM_readData = rdata;

    task automatic preload(input logic [11:0] w, input logic [63:0] d);
        pl_en = 1'b1; pl_word = w; pl_data = d; ref_mem[w] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [2:0] wid, output logic [63:0] got);
        int unsigned size, off, ne, nb, lat, exp_lat, g, p;
        logic        trap, busy_rdy, stray_be, seen, gfault;
        logic [14:0] b;
        logic [11:0] ew [2];
        logic [7:0]  ebe [2];
        logic [63:0] ewd [2];
        logic [11:0] gw [4];
        logic [7:0]  gbe [4];
        logic [63:0] gwd [4];
        logic [1:0]  gstb [4];
        logic [63:0] exp_d;
        size = 1 << wid[1:0];
        off  = addr[2:0];
        trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (off % size) != 0;
`endif
        ne = 0; exp_d = '0;
        for (int k = 0; k < 2; k++) begin ew[k] = '0; ebe[k] = '0; ewd[k] = '0; end
        if (!trap) begin
            for (int i = 0; i < int'(size); i++) begin
                b = addr[14:0] + 15'(i);
                if (ne == 0 || b[14:3] != ew[ne-1]) begin ew[ne] = b[14:3]; ne++; end
                ebe[ne-1][b[2:0]] = 1'b1;
                if (!wr) exp_d[8*i +: 8] = ref_mem[b[14:3]][8*b[2:0] +: 8];
            end
            if (!wr && !wid[2] && exp_d[8*size-1])
                for (int i = int'(size); i < 8; i++) exp_d[8*i +: 8] = 8'hFF;
            if (wr) begin
                for (int j = 0; j < 8; j++) begin
                    p = off + j;
                    if (p < 8) ewd[0][8*p +: 8] = wd[8*j +: 8];
                    else if (ne == 2) ewd[1][8*(p-8) +: 8] = wd[8*j +: 8];
                end
            end
        end
        exp_lat = trap ? 1 : 1 + ne + (wr ? 0 : 1);

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; memWidth = wid;
        g = 0;
        while (!req_ready && g < 8) begin @(negedge clk); g++; end
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'($urandom); memWidth = 3'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};

        nb = 0; lat = 0; seen = 0; busy_rdy = 0; stray_be = 0; gfault = 0; got = '0;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            if (readEnable || writeEnable) begin
                if (nb < 4) begin
                    gw[nb] = wordAddr; gbe[nb] = byteena; gwd[nb] = DM_writeData;
                    gstb[nb] = {writeEnable, readEnable};
                end
                nb++;
            end else if (byteena != 8'h00) stray_be = 1'b1;
            if (req_ready) busy_rdy = 1'b1;
            if (resp_valid) begin seen = 1'b1; lat = k; got = resp_data; gfault = resp_fault; end
        end

        n_vec++;
        if (lat !== exp_lat) begin
            n_err++; $display("FAIL latency addr=%h: got %0d cycles (0=timeout) required %0d", addr, lat, exp_lat);
        end
        n_vec++;
        if (nb !== ne) begin
            n_err++; $display("FAIL beat_count addr=%h: got %0d required %0d", addr, nb, ne);
        end
        for (int k = 0; k < int'(ne) && k < int'(nb) && k < 4; k++) begin
            n_vec++;
            if (gw[k] !== ew[k] || gbe[k] !== ebe[k] || gstb[k] !== (wr ? 2'b10 : 2'b01)
                || (wr && gwd[k] !== ewd[k])) begin
                n_err++;
                $display("FAIL beat%0d addr=%h: word/be/stb/wdata got %h/%h/%b/%h required %h/%h/%b/%h",
                         k, addr, gw[k], gbe[k], gstb[k], gwd[k], ew[k], ebe[k],
                         (wr ? 2'b10 : 2'b01), ewd[k]);
            end
        end
        n_vec++;
        if (busy_rdy || stray_be) begin
            n_err++; $display("FAIL busy_outputs: ready_seen=%b stray_be=%b required 0/0", busy_rdy, stray_be);
        end
        n_vec++;
        if (got !== exp_d) begin
            n_err++; $display("FAIL resp_data addr=%h w=%b: got %h required %h", addr, wid, got, exp_d);
        end
        n_vec++;
        if (gfault !== trap) begin
            n_err++; $display("FAIL resp_fault: got %b required %b", gfault, trap);
        end
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL resp_pulse: valid/ready got %b/%b required 0/1", resp_valid, req_ready);
        end
        if (wr && !trap) begin
            for (int i = 0; i < int'(size); i++) begin
                b = addr[14:0] + 15'(i);
                ref_mem[b[14:3]][8*b[2:0] +: 8] = wd[8*i +: 8];
            end
            for (int k = 0; k < int'(ne); k++) begin
                n_vec++;
                if (mem[ew[k]] !== ref_mem[ew[k]]) begin
                    n_err++; $display("FAIL mem_word %h: got %h required %h", ew[k], mem[ew[k]], ref_mem[ew[k]]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h86;
        req_wdata = 64'h1234; memWidth = 3'b011;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({req_ready, resp_valid, resp_fault, readEnable, writeEnable, byteena} !== 13'b1_0000_0000_0000
            || resp_data !== '0 || wordAddr !== '0 || DM_writeData !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b rv=%b rf=%b re=%b we=%b be=%h rd=%h wa=%h wd=%h required 1,0s",
                     req_ready, resp_valid, resp_fault, readEnable, writeEnable, byteena,
                     resp_data, wordAddr, DM_writeData);
        end
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: ready/valid got %b/%b required 1/0", req_ready, resp_valid);
        end
    endtask

    task automatic test_plan();
        logic [63:0] got;
        preload(12'h010, 64'h8877665544332211);
        preload(12'h011, 64'hFFEEDDCCBBAA9988);
        do_req(1'b0, 64'h84, 64'h0, 3'b010, got);
        n_vec++;
        if (got !== 64'hFFFFFFFF88776655) begin
            n_err++; $display("FAIL plan_lw: got %h required FFFFFFFF88776655", got);
        end
        do_req(1'b0, 64'h83, 64'h0, 3'b011, got);
        n_vec++;
        if (got !== 64'hAA99888877665544) begin
            n_err++; $display("FAIL plan_ld_split: got %h required AA99888877665544", got);
        end
        do_req(1'b1, 64'h86, 64'hDEADBEEF, 3'b010, got);
        n_vec++;
        if (mem[12'h010] !== 64'hBEEF665544332211 || mem[12'h011] !== 64'hFFEEDDCCBBAADEAD) begin
            n_err++; $display("FAIL plan_sw_split: words %h %h required BEEF665544332211 FFEEDDCCBBAADEAD",
                              mem[12'h010], mem[12'h011]);
        end
        do_req(1'b0, 64'h7FFF, 64'h0, 3'b101, got);
        n_vec++;
        if (got[63:16] !== 48'h0) begin
            n_err++; $display("FAIL plan_lhu_wrap: upper bits got %h required 0", got[63:16]);
        end
        preload(12'h010, 64'h8877665544332211);
        preload(12'h011, 64'hFFEEDDCCBBAA9988);
        do_req(1'b0, 64'h86, 64'h0, 3'b010, got);
        n_vec++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (got !== 64'h0) begin
            n_err++; $display("FAIL plan_misalign: got %h required 0", got);
        end
`else
        if (got !== 64'hFFFFFFFF99888877) begin
            n_err++; $display("FAIL plan_misalign: got %h required FFFFFFFF99888877", got);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [63:0] got;
        logic        seen;
        preload(12'h010, 64'h8877665544332211);
        preload(12'h011, 64'hFFEEDDCCBBAA9988);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h83; memWidth = 3'b011;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
`ifdef LSU_MISALIGN_TRAP_EN
        if (resp_valid !== 1'b0 && resp_fault !== 1'b1) begin
            n_err++; $display("FAIL mid_beat1: trap response state unexpected");
        end
`else
        if (readEnable !== 1'b1 || wordAddr !== 12'h011 || byteena !== 8'h07) begin
            n_err++; $display("FAIL mid_beat1: re/wa/be got %b/%h/%h required 1/011/07",
                              readEnable, wordAddr, byteena);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req_ready, readEnable, writeEnable, byteena, resp_valid} !== 12'b1_0_0_00000000_0) begin
            n_err++; $display("FAIL mid_reset: rdy/re/we/be/rv got %b/%b/%b/%h/%b required 1/0/0/00/0",
                              req_ready, readEnable, writeEnable, byteena, resp_valid);
        end
        reset = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++; $display("FAIL mid_no_resp: resp_valid seen=%b required 0", seen);
        end
        do_req(1'b0, 64'h80, 64'h0, 3'b000, got);
        n_vec++;
        if (got !== 64'h11) begin
            n_err++; $display("FAIL mid_lb: got %h required 0000000000000011", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, d;
        d = {$urandom, $urandom};
        do_req(1'b1, 64'h203, d, 3'b011, got);
        do_req(1'b0, 64'h203, 64'h0, 3'b011, got);
        n_vec++;
        if (got !== d) begin
            n_err++; $display("FAIL b2b_raw: got %h required %h", got, d);
        end
        do_req(1'b1, 64'h20E, d, 3'b001, got);
        do_req(1'b0, 64'h20E, 64'h0, 3'b100, got);
    endtask

    task automatic test_random();
        logic [63:0] got, a;
        for (int t = 0; t < 150; t++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) a[14:6] = '0;
            do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 3'($urandom_range(0, 7)), got);
        end
    endtask

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; memWidth = '0;
        test_reset();
        for (int w = 0; w < 4096; w++) preload(12'(w), {$urandom, $urandom});
        @(negedge clk);
        test_plan();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator sitting between the pipeline memory stage and the byte-enabled data-memory port.
- Accepts one load/store request at a time and issues one or two word beats to memory. Two beats are used when the access crosses a 64-bit word boundary.
- Generates the byte-enable masks and the shifted write data.
- Reassembles and sign- or zero-extends read data, then returns one response per request.

Parameters:
N, 64, data/address width in bits (memory word = N bits = 8 bytes)
AW, 12, memory word-address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (IDLE only)
req_write  in  1  1=store, 0=load
req_addr  in  N  byte address; bits [AW+2:3] are the word, [2:0] the offset, higher bits ignored
req_wdata  in  N  store data, right-aligned
memWidth  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 treated as d
resp_valid  out  1  one-cycle response pulse
resp_data  out  N  extended load data (0 for stores)
resp_fault  out  1  misaligned fault (see Optional Feature)
wordAddr  out  AW  memory word address
DM_writeData  out  N  shifted store data
byteena  out  8  byte enables
readEnable  out  1  memory read strobe
writeEnable  out  1  memory write strobe
DM_readData  in  N  memory read data, valid the cycle after readEnable

Behaviour:
- Reset (sync, active-low, checked every edge):
  - State returns to IDLE.
  - req_ready=1, resp_valid=0, resp_data=0, resp_fault=0, wordAddr=0, DM_writeData=0, byteena=0, readEnable=0, writeEnable=0.
  - Reset asserted mid-operation drops the in-flight request with no response. A beat already issued is not undone.
- Request acceptance and latching:
  - A request is accepted on an edge where req_valid&&req_ready. At that edge the block latches addr, wdata, memWidth and write.
  - size = 1<<memWidth[1:0]; off = addr[2:0]; split = (off+size > 8).
- States: IDLE -> BEAT0 -> [BEAT1 if split] -> [CAPT if load] -> RESP -> IDLE.
- Memory strobes:
  - readEnable/writeEnable are high only in BEAT0/BEAT1; exactly one of them is high, matching req_write.
  - byteena is 0 outside the beats.
- BEAT0:
  - wordAddr = latched word.
  - byteena = ((1<<size)-1)<<off, truncated to 8 bits.
  - DM_writeData = wdata << 8*off.
- BEAT1:
  - wordAddr = word+1, mod 2^AW (2^AW-1 wraps to 0).
  - byteena = (1<<(off+size-8))-1.
  - DM_writeData = wdata >> 8*(8-off).
  - For loads, the beat-0 DM_readData is registered as lo in this state.
- CAPT:
  - Non-split: lo = DM_readData.
  - Split: hi = DM_readData.
- Load assembly:
  - value = ({hi,lo} >> 8*off), truncated to size bytes.
  - Sign-extended when memWidth[2]=0, zero-extended otherwise.
  - Registered into resp_data on entry to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_data holds until the next response.
- Latency, accept edge to resp_valid high:
  - non-split load 3 cycles; split load 4.
  - non-split store 2 cycles; split store 3.
- Throughput: next request is accepted no earlier than the cycle after RESP.
- Outputs are registered; no combinational path from req_* to memory outputs.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - A request with addr not a multiple of size goes IDLE -> RESP directly, with resp_fault=1, resp_data=0 and no memory strobes. resp_valid is asserted 1 cycle after accept.
  - Aligned accesses behave as above (split never occurs).
- Undefined: resp_fault is tied 0 and misaligned accesses are split as described.

Test Plan:
Preload word 0x010=0x8877665544332211, word 0x011=0xFFEEDDCCBBAA9988.
1. lw addr 0x84 -> one beat: wordAddr 0x010, byteena 0xF0; resp_data 0xFFFFFFFF88776655 3 cycles after accept.
2. ld addr 0x83 -> beats: 0x010/0xF8 then 0x011/0x07; resp_data 0xAA99888877665544 4 cycles after accept.
3. sw 0xDEADBEEF addr 0x86 -> beat0 wordAddr 0x010, byteena 0xC0, DM_writeData 0xBEEF000000000000; beat1 0x011, byteena 0x03, DM_writeData 0x000000000000DEAD; resp_valid 3 cycles after accept, resp_data 0.
4. lhu addr 0x7FFF (word 0xFFF, off 7) -> beat0 0xFFF/0x80, beat1 wraps to wordAddr 0x000/0x01; resp upper 48 bits zero.
5. reset=0 during BEAT1 of test-2 load -> next cycle req_ready=1, all strobes 0, no resp_valid; a following lb 0x80 returns 0x0000000000000011.
6. LSU_MISALIGN_TRAP_EN defined, lw addr 0x86 -> no readEnable, resp_valid+resp_fault 1 cycle after accept; without macro -> two-beat split, resp_data 0xFFFFFFFF99888877.
